// File: rtl/ksa_shuffle.sv
// ksa_shuffle -- RC4 key-scheduling stage.
//
// Permutes the 256-entry S-box held in an external RAM using the secret key:
//   for i = 0..255: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]
// and raises finish when done. The downstream PRGA stage consumes the result.
//
// Configuration macro: KSA_INIT_EN
//   defined   : an INIT state fills S[n] = n before shuffling (256 extra cycles).
//   undefined : S must already hold the identity permutation when start arrives.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high
//   start           in   level request, accepted only in IDLE
//   secret_key      in   key, captured when a run begins (byte 0 is the MSB byte)
//   q_data          in   S RAM read data, valid READ_LAT cycles after address
//   finish          out  high in DONE
//   ksa_mem_handler out  high while this stage owns the S RAM
//   address         out  S RAM address (registered)
//   data            out  S RAM write data (registered)
//   wen             out  S RAM write enable (registered)
module ksa_shuffle #(
    parameter int KEY_BYTES = 3,
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q_data,
    output logic                   finish,
    output logic                   ksa_mem_handler,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wen
);

    localparam int            KW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [7:0]    LAST_IDX = 8'(DEPTH - 1);
    localparam logic [7:0]    RD_LAST  = 8'(READ_LAT - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(KEY_BYTES - 1);

`ifdef KSA_INIT_EN
    typedef enum logic [2:0] {IDLE, INIT, RD_SI, CALC_J, RD_SJ, WR_I, WR_J, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD_SI, CALC_J, RD_SJ, WR_I, WR_J, DONE} state_t;
`endif

    state_t                 state, state_n;
    logic [7:0]             i, i_n, j, j_n, si, si_n, sj, sj_n;
    logic [7:0]             rd_cnt, rd_cnt_n;
    logic [KW-1:0]          kcnt, kcnt_n;
    logic [8*KEY_BYTES-1:0] key, key_n;
    logic [7:0]             address_n, data_n;
    logic                   wen_n, finish_n, handler_n;

    // Key byte selected by the wrap counter; byte 0 sits in the top bits.
    function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] k,
                                            input logic [KW-1:0] idx);
        logic [7:0] b;
        b = 8'd0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (idx == KW'(n)) b = k[8*(KEY_BYTES-n)-1 -: 8];
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            i               <= 8'd0;
            j               <= 8'd0;
            si              <= 8'd0;
            sj              <= 8'd0;
            rd_cnt          <= 8'd0;
            kcnt            <= '0;
            key             <= '0;
            address         <= 8'd0;
            data            <= 8'd0;
            wen             <= 1'b0;
            finish          <= 1'b0;
            ksa_mem_handler <= 1'b0;
        end else begin
            state           <= state_n;
            i               <= i_n;
            j               <= j_n;
            si              <= si_n;
            sj              <= sj_n;
            rd_cnt          <= rd_cnt_n;
            kcnt            <= kcnt_n;
            key             <= key_n;
            address         <= address_n;
            data            <= data_n;
            wen             <= wen_n;
            finish          <= finish_n;
            ksa_mem_handler <= handler_n;
        end
    end

    always_comb begin
        state_n  = state;
        i_n      = i;
        j_n      = j;
        si_n     = si;
        sj_n     = sj;
        rd_cnt_n = rd_cnt;
        kcnt_n   = kcnt;
        key_n    = key;

        case (state)
            IDLE: begin
                if (start) begin
`ifdef KSA_INIT_EN
                    state_n = INIT;
`else
                    state_n = RD_SI;
`endif
                    key_n    = secret_key;
                    i_n      = 8'd0;
                    j_n      = 8'd0;
                    kcnt_n   = '0;
                    rd_cnt_n = 8'd0;
                end
            end
`ifdef KSA_INIT_EN
            // i doubles as the fill counter and wraps back to 0 for the shuffle.
            INIT: begin
                i_n = i + 8'd1;
                if (i == LAST_IDX) state_n = RD_SI;
            end
`endif
            RD_SI: begin
                if (rd_cnt == RD_LAST) begin
                    si_n     = q_data;
                    rd_cnt_n = 8'd0;
                    state_n  = CALC_J;
                end else begin
                    rd_cnt_n = rd_cnt + 8'd1;
                end
            end
            CALC_J: begin
                j_n     = j + si + key_byte(key, kcnt);
                state_n = RD_SJ;
            end
            RD_SJ: begin
                if (rd_cnt == RD_LAST) begin
                    sj_n     = q_data;
                    rd_cnt_n = 8'd0;
                    state_n  = WR_I;
                end else begin
                    rd_cnt_n = rd_cnt + 8'd1;
                end
            end
            WR_I: state_n = WR_J;
            WR_J: begin
                i_n     = i + 8'd1;
                kcnt_n  = (kcnt == K_LAST) ? '0 : kcnt + KW'(1);
                state_n = (i == LAST_IDX) ? DONE : RD_SI;
            end
            DONE: begin
                if (!start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        address_n = address;
        data_n    = data;
        wen_n     = 1'b0;
        case (state_n)
`ifdef KSA_INIT_EN
            INIT: begin
                address_n = i_n;
                data_n    = i_n;
                wen_n     = 1'b1;
            end
`endif
            RD_SI:  address_n = i_n;
            RD_SJ:  address_n = j_n;
            WR_I: begin
                address_n = i_n;
                data_n    = sj_n;
                wen_n     = 1'b1;
            end
            WR_J: begin
                address_n = j_n;
                data_n    = si_n;
                wen_n     = 1'b1;
            end
            default: ;
        endcase
        finish_n  = (state_n == DONE);
        handler_n = (state_n != IDLE) && (state_n != DONE);
    end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Directed bench for ksa_shuffle: behavioural S RAM with a 2-cycle read,
// table of keys with hand-derived first writes, C-style reference model for
// the final permutation, plus hold-in-DONE and mid-run reset sequences.
module tb_ksa_shuffle;

    localparam int RL = 2;
`ifdef KSA_INIT_EN
    localparam int INIT_CYC = 256;
    localparam bit HAS_INIT = 1'b1;
`else
    localparam int INIT_CYC = 0;
    localparam bit HAS_INIT = 1'b0;
`endif
    localparam int RUN_CYC = 256 * (2 * RL + 3) + INIT_CYC;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [23:0] secret_key;
    logic [7:0]  q_data;
    logic        finish, ksa_mem_handler, wen;
    logic [7:0]  address, data;

    always #5 clk = ~clk;

    ksa_shuffle #(.KEY_BYTES(3), .DEPTH(256), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .q_data(q_data), .finish(finish), .ksa_mem_handler(ksa_mem_handler),
        .address(address), .data(data), .wen(wen)
    );

    // S RAM: synchronous write, registered read (2 cycles address -> capture).
    logic [7:0] mem [256];
    logic [7:0] q_reg;
    int         fill_mode = 0;   // 1: identity, 2: scrambled
    always @(posedge clk) begin
        q_reg <= mem[address];
        if (fill_mode == 1) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (fill_mode == 2) begin
            for (int n = 0; n < 256; n++) mem[n] <= ~8'(n);
        end else if (wen) begin
            mem[address] <= data;
        end
    end
    assign q_data = q_reg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log and protocol monitor.
    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];
    int mon_err = 0;
    int wen_run = 0;
    always @(negedge clk) begin
        if (wen) begin
            wr_a.push_back(address);
            wr_d.push_back(data);
        end
        wen_run = wen ? wen_run + 1 : 0;
        if (wen && !ksa_mem_handler) begin
            mon_err++;
            $display("monitor: wen without ksa_mem_handler at %0t", $time);
        end
        if (finish && ksa_mem_handler) begin
            mon_err++;
            $display("monitor: finish with ksa_mem_handler at %0t", $time);
        end
        if (!HAS_INIT && wen_run > 2) begin
            mon_err++;
            $display("monitor: wen high more than two cycles at %0t", $time);
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] ref_s [256];
    function automatic void model(input logic [23:0] k);
        logic [7:0] jj, t, kb;
        for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
        jj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            kb = 8'(k >> (8 * (2 - (n % 3))));
            jj = jj + ref_s[n] + kb;
            t = ref_s[n];
            ref_s[n] = ref_s[jj];
            ref_s[jj] = t;
        end
    endfunction

    task automatic fill_ram();
        @(negedge clk);
        fill_mode = HAS_INIT ? 2 : 1;
        @(negedge clk);
        fill_mode = 0;
        wr_a.delete();
        wr_d.delete();
    endtask

    // Raise start, measure handler-rise to finish-rise; key is scrambled mid-run.
    task automatic run_key(input logic [23:0] k, output int cycles);
        int t0, t1;
        t0 = -1;
        t1 = -1;
        secret_key = k;
        start = 1'b1;
        for (int n = 0; n < RUN_CYC + 50; n++) begin
            @(negedge clk);
            if (t0 < 0 && ksa_mem_handler) begin
                t0 = cyc;
                secret_key = 24'h5A5A5A;
            end
            if (finish) begin
                t1 = cyc;
                break;
            end
        end
        cycles = (t0 >= 0 && t1 >= 0) ? t1 - t0 : -1;
    endtask

    task automatic check_final(input string nm);
        int mism;
        mism = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== ref_s[n]) mism++;
        check(nm, 64'(mism), 64'd0);
    endtask

    typedef struct packed {
        logic [23:0] key;
        logic [31:0] wa;   // first four write addresses, first in top byte
        logic [31:0] wd;   // first four write data values
    } vec_t;
    vec_t vecs [4];

    initial begin
        int cycles, off, sz;
        logic [31:0] wa, wd;
        logic [7:0]  ea, ed, aa, ad;

        vecs[0] = '{key: 24'h000249, wa: 32'h00000103, wd: 32'h00000301};
        vecs[1] = '{key: 24'h000000, wa: 32'h00000101, wd: 32'h00000101};
        vecs[2] = '{key: 24'hFFFFFF, wa: 32'h00FF01FF, wd: 32'hFF000001};
        vecs[3] = '{key: 24'h010203, wa: 32'h00010103, wd: 32'h01000300};
        off = INIT_CYC;

        reset = 1'b1;
        start = 1'b0;
        secret_key = 24'h0;
        repeat (3) @(negedge clk);
        check("rst_address", 64'(address), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_wen", 64'(wen), 64'd0);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_handler", 64'(ksa_mem_handler), 64'd0);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            fill_ram();
            model(vecs[v].key);
            run_key(vecs[v].key, cycles);
            check("run_cycles", 64'(cycles), 64'(RUN_CYC));
            wa = vecs[v].wa;
            wd = vecs[v].wd;
            for (int k = 0; k < 4; k++) begin
                ea = wa[31-8*k -: 8];
                ed = wd[31-8*k -: 8];
                aa = (wr_a.size() > off + k) ? wr_a[off+k] : 8'hxx;
                ad = (wr_d.size() > off + k) ? wr_d[off+k] : 8'hxx;
                check("first_wr_addr", 64'(aa), 64'(ea));
                check("first_wr_data", 64'(ad), 64'(ed));
            end
            check_final("final_s");
            check("write_count", 64'(wr_a.size()), 64'(off + 512));
            // Start held high in DONE: no retrigger, no RAM activity.
            sz = wr_a.size();
            repeat (6) @(negedge clk);
            check("done_hold_finish", 64'(finish), 64'd1);
            check("done_hold_writes", 64'(wr_a.size()), 64'(sz));
            start = 1'b0;
            @(negedge clk);
            check("drop_start_finish", 64'(finish), 64'd0);
        end

        // Abort at iteration 100.
        fill_ram();
        secret_key = 24'h000249;
        start = 1'b1;
        for (int n = 0; n < RUN_CYC && wr_a.size() < off + 200; n++) @(negedge clk);
        check("reached_iter_100", 64'(wr_a.size() >= off + 200), 64'd1);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("abort_wen", 64'(wen), 64'd0);
        check("abort_handler", 64'(ksa_mem_handler), 64'd0);
        check("abort_finish", 64'(finish), 64'd0);
        sz = wr_a.size();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_writes", 64'(wr_a.size()), 64'(sz));

        // Fresh run after the abort restarts from i=0, j=0.
        fill_ram();
        model(24'h000249);
        run_key(24'h000249, cycles);
        check("rerun_cycles", 64'(cycles), 64'(RUN_CYC));
        check_final("rerun_final_s");
        start = 1'b0;
        @(negedge clk);

        check("monitor_violations", 64'(mon_err), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
